// File: rtl/clk_tick_gen.sv
// clk_tick_gen: multi-channel programmable tick / square-wave generator.
// Divisor and mode updates are staged and applied only at period boundaries.
module clk_tick_gen #(
  parameter int CHANNELS  = 4,
  parameter int DIV_W     = 16,
  parameter int DIV_RESET = 2,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_tick_gen_fsys,
  input  logic                clk_tick_gen_rst,
  input  logic [CHANNELS-1:0] clk_tick_gen_en,
  input  logic                clk_tick_gen_cfg_valid,
  output logic                clk_tick_gen_cfg_ready,
  input  logic [CH_W-1:0]     clk_tick_gen_cfg_ch,
  input  logic [DIV_W-1:0]    clk_tick_gen_cfg_div,
  input  logic                clk_tick_gen_cfg_oneshot,
  output logic [CHANNELS-1:0] clk_tick_gen_tick,
  output logic [CHANNELS-1:0] clk_tick_gen_sq,
  output logic [CHANNELS-1:0] clk_tick_gen_done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  localparam logic [DIV_W-1:0] DIV_INIT =
    (DIV_RESET == 0) ? DIV_W'(1) : DIV_W'(DIV_RESET);

  logic [CHANNELS-1:0] pend_v;
  logic                xfer;
  logic [DIV_W-1:0]    wdiv;

  // Ready reflects the addressed channel; out-of-range channels always accept.
  always_comb begin
    clk_tick_gen_cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (clk_tick_gen_cfg_ch == CH_W'(i)) begin
        clk_tick_gen_cfg_ready = !pend_v[i];
      end
    end
  end

  assign xfer = clk_tick_gen_cfg_valid && clk_tick_gen_cfg_ready;
  assign wdiv = (clk_tick_gen_cfg_div == '0) ? DIV_W'(1)
                                             : clk_tick_gen_cfg_div;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           state, nstate;
    logic [DIV_W-1:0] div, cnt, ncnt, pdiv, ndiv, last;
    logic [DIV_W:0]   half;
    logic             mode, pmode, pend, nmode;
    logic             term, apply, wr, en;
    logic             tick_r, sq_r, done_r;

    assign en    = clk_tick_gen_en[i];
    assign last  = div - 1'b1;
    assign term  = (state == RUN) && (cnt == last);
    assign apply = pend && ((state != RUN) || term);
    assign ndiv  = apply ? pdiv : div;
    assign nmode = apply ? pmode : mode;
    assign half  = ({1'b0, ndiv} + 1'b1) >> 1;
    assign wr    = xfer && (clk_tick_gen_cfg_ch == CH_W'(i));

    // Next state and count for the coming edge.
    always_comb begin
      nstate = state;
      ncnt   = cnt;
      if (!en) begin
        nstate = IDLE;
        ncnt   = '0;
      end else begin
        unique case (state)
          IDLE: begin
            nstate = RUN;
            ncnt   = '0;
          end
          RUN: begin
            if (term) begin
              nstate = mode ? HOLD : RUN;
              ncnt   = '0;
            end else begin
              ncnt = cnt + 1'b1;
            end
          end
          HOLD: ncnt = '0;
          default: begin
            nstate = IDLE;
            ncnt   = '0;
          end
        endcase
      end
    end

    // Channel state, staged config and registered outputs.
    always_ff @(posedge clk_tick_gen_fsys or posedge clk_tick_gen_rst) begin
      if (clk_tick_gen_rst) begin
        state  <= IDLE;
        cnt    <= '0;
        div    <= DIV_INIT;
        mode   <= 1'b0;
        pdiv   <= DIV_INIT;
        pmode  <= 1'b0;
        pend   <= 1'b0;
        tick_r <= 1'b0;
        sq_r   <= 1'b0;
        done_r <= 1'b0;
      end else begin
        state <= nstate;
        cnt   <= ncnt;
        div   <= ndiv;
        mode  <= nmode;
        if (wr) begin
          pdiv  <= wdiv;
          pmode <= clk_tick_gen_cfg_oneshot;
          pend  <= 1'b1;
        end else if (apply) begin
          pend <= 1'b0;
        end
        tick_r <= en && term;
        sq_r   <= (nstate == RUN) && ({1'b0, ncnt} < half);
        done_r <= (nstate == HOLD);
      end
    end

    assign pend_v[i]            = pend;
    assign clk_tick_gen_tick[i] = tick_r;
    assign clk_tick_gen_sq[i]   = sq_r;
    assign clk_tick_gen_done[i] = done_r;
  end

endmodule

// File: tb/tb_clk_tick_gen.sv
// tb_clk_tick_gen: directed self-checking bench for clk_tick_gen.
// Expected values are hand-derived from the tick/sq/done timing rules.
module tb_clk_tick_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en;
  logic        valid;
  logic        ready;
  logic [1:0]  ch;
  logic [15:0] div;
  logic        os;
  logic [3:0]  tick, sq, done;

  int checks = 0;
  int errors = 0;

  clk_tick_gen dut (
    .clk_tick_gen_fsys        (clk),
    .clk_tick_gen_rst         (rst),
    .clk_tick_gen_en          (en),
    .clk_tick_gen_cfg_valid   (valid),
    .clk_tick_gen_cfg_ready   (ready),
    .clk_tick_gen_cfg_ch      (ch),
    .clk_tick_gen_cfg_div     (div),
    .clk_tick_gen_cfg_oneshot (os),
    .clk_tick_gen_tick        (tick),
    .clk_tick_gen_sq          (sq),
    .clk_tick_gen_done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] c, input logic [15:0] d,
                      input logic o);
    valid = 1'b1;
    ch    = c;
    div   = d;
    os    = o;
    step();
    valid = 1'b0;
    step();
  endtask

  initial begin
    rst   = 1'b1;
    en    = '0;
    valid = 1'b0;
    ch    = '0;
    div   = '0;
    os    = 1'b0;
    step();
    step();
    chk("rst_tick", tick, 0);
    chk("rst_sq", sq, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", ready, 1);
    rst = 1'b0;
    step();

    en = 4'b0001;
    for (int j = 0; j < 6; j++) begin
      step();
      chk("d2_tick", tick, (j > 0 && j % 2 == 0) ? 1 : 0);
      chk("d2_sq", sq, (j % 2 == 0) ? 1 : 0);
    end
    en = '0;
    step();
    chk("off_tick", tick, 0);
    chk("off_sq", sq, 0);

    valid = 1'b1;
    ch    = 2'd1;
    div   = 16'd5;
    os    = 1'b0;
    chk("c1_rdy_pre", ready, 1);
    step();
    valid = 1'b0;
    chk("c1_rdy_low", ready, 0);
    step();
    chk("c1_rdy_back", ready, 1);
    en = 4'b0010;
    for (int j = 0; j < 11; j++) begin
      step();
      chk("d5_tick", tick, (j == 5 || j == 10) ? 2 : 0);
      chk("d5_sq", sq, (j % 5 < 3) ? 2 : 0);
    end
    en = '0;
    step();

    load(2'd0, 16'd8, 1'b0);
    en = 4'b0001;
    step();
    chk("d8_start", tick, 0);
    for (int j = 1; j < 27; j++) begin
      step();
      chk("d8to3_tick", tick,
          (j == 8 || j == 16 || j == 19 || j == 22 || j == 25) ? 1 : 0);
      if (j == 12) begin
        valid = 1'b1;
        ch    = 2'd0;
        div   = 16'd3;
      end
      if (j == 13) begin
        div = 16'd6;
        chk("busy_rdy", ready, 0);
      end
      if (j == 14) valid = 1'b0;
      if (j == 15) chk("pend_rdy", ready, 0);
      if (j == 16) chk("appl_rdy", ready, 1);
    end
    en = '0;
    step();

    en = 4'b0001;
    step();
    for (int j = 1; j < 18; j++) begin
      step();
      chk("tc_tick", tick,
          (j == 3 || j == 6 || j == 11 || j == 16) ? 1 : 0);
      if (j == 2) begin
        valid = 1'b1;
        ch    = 2'd0;
        div   = 16'd5;
        chk("tc_rdy", ready, 1);
      end
      if (j == 3) begin
        valid = 1'b0;
        chk("tc_pend", ready, 0);
      end
      if (j == 6) chk("tc_appl", ready, 1);
    end
    en = '0;
    step();

    load(2'd2, 16'd4, 1'b1);
    en = 4'b0100;
    for (int j = 0; j < 11; j++) begin
      step();
      chk("os_tick", tick, (j == 4) ? 4 : 0);
      chk("os_sq", sq, (j < 2) ? 4 : 0);
      chk("os_done", done, (j >= 4) ? 4 : 0);
    end
    en = '0;
    step();
    chk("os_off_done", done, 0);
    chk("os_off_tick", tick, 0);
    en = 4'b0100;
    for (int j = 0; j < 6; j++) begin
      step();
      chk("os2_tick", tick, (j == 4) ? 4 : 0);
      chk("os2_done", done, (j >= 4) ? 4 : 0);
    end
    en = '0;
    step();

    load(2'd3, 16'd0, 1'b0);
    en = 4'b1000;
    step();
    chk("d0_first", tick, 0);
    chk("d0_sq0", sq, 8);
    for (int j = 1; j < 5; j++) begin
      step();
      chk("d0_tick", tick, 8);
      chk("d0_sq", sq, 8);
    end
    en = 4'b1111;
    step();
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_tick", tick, 0);
    chk("arst_sq", sq, 0);
    chk("arst_done", done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ch  = 2'd3;
    chk("arst_rdy", ready, 1);
    for (int j = 0; j < 5; j++) begin
      step();
      chk("post_tick", tick, (j > 0 && j % 2 == 0) ? 4'hf : 0);
      chk("post_sq", sq, (j % 2 == 0) ? 4'hf : 0);
      chk("post_done", done, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_tick_gen.md
# clk_tick_gen

Multi-channel programmable tick and clock-enable generator for the system clock domain. It supersedes the single power-of-two divider tap. Each of CHANNELS channels divides the system clock by an arbitrary integer and produces:
- a registered single-cycle tick;
- a registered near-50% square output.

Divisor and mode are reconfigured through a valid/ready port, and updates take effect only at a period boundary, so outputs never glitch. Counters, display scanners and debouncers use it as their rate source in place of per-module dividers.

## Interface
Parameters:
- CHANNELS, 4: number of independent channels (1..16).
- DIV_W, 16: divisor width.
- DIV_RESET, 2: divisor loaded into every channel at reset.
- CH_W: localparam, max(1, $clog2(CHANNELS)).

Ports:
- clk_tick_gen_fsys  in  1  system clock; all logic on its rising edge.
- clk_tick_gen_rst  in  1  reset, asynchronous, active-high.
- clk_tick_gen_en  in  CHANNELS  per-channel run enable (level).
- clk_tick_gen_cfg_valid  in  1  configuration request.
- clk_tick_gen_cfg_ready  out  1  combinational: high when channel clk_tick_gen_cfg_ch has no pending update.
- clk_tick_gen_cfg_ch  in  CH_W  target channel; values >= CHANNELS are accepted and discarded.
- clk_tick_gen_cfg_div  in  DIV_W  new divisor D; 0 is treated as 1.
- clk_tick_gen_cfg_oneshot  in  1  new mode: 0 continuous, 1 one-shot.
- clk_tick_gen_tick  out  CHANNELS  single-cycle tick per period.
- clk_tick_gen_sq  out  CHANNELS  square output.
- clk_tick_gen_done  out  CHANNELS  one-shot completed (level).

## Operation
- Per-channel state: active divisor, active mode, count (DIV_W bits), pending divisor, pending mode, pending flag, FSM state.
- FSM states: IDLE, RUN, HOLD.
  - IDLE→RUN when en=1; count<=0.
  - RUN→HOLD at terminal count (count==D-1) when mode is one-shot.
  - RUN/HOLD→IDLE when en=0.
- RUN count: increments each cycle and wraps D-1→0.
- Registered outputs:
  - tick <= (state==RUN && count==D-1).
  - sq <= (next state==RUN && next count < (D+1)>>1).
  - done <= (next state==HOLD).
- Square output duty: high for ceil(D/2) cycles, low for floor(D/2). With D=1, sq is constantly 1 and tick fires every cycle.
- Configuration handshake:
  - Transfer occurs on a cycle with valid && ready. The pending divisor and mode are written and the pending flag is set.
  - valid may be held high; each transfer is a single accept.
- Pending update is applied (active <= pending, flag cleared) on the first edge where either:
  - state is IDLE or HOLD, or
  - state is RUN and count==D-1; the new period then starts at count 0.
- Simultaneous events:
  - Transfer in the same cycle as a terminal count: applied at the following terminal count, not the current one.
  - Transfer into an IDLE channel: applied on the next edge.
- Changing mode to one-shot while in RUN: takes effect at the boundary, so one full new period runs before HOLD.
- en=0 does not discard a pending update.
- Reset (asynchronous, including mid-period) sets:
  - state IDLE, count 0;
  - active divisor DIV_RESET, mode continuous;
  - pending flag 0;
  - tick, sq, done all 0.
- Channels are fully independent; a configuration port collision is impossible because there is one port.

## Timing
- en sampled 1 at edge k:
  - sq=1 from edge k;
  - first tick visible after edge k+D, lasting one cycle;
  - subsequent ticks every D cycles.
- en sampled 0 at edge k: tick, sq and done are 0 after edge k. A tick that would have fired at edge k is suppressed.
- One-shot:
  - exactly one tick after edge k+D;
  - done=1 after edge k+D, held until en=0;
  - sq=0 in HOLD.
- clk_tick_gen_cfg_ready: deasserts the cycle after a transfer and reasserts the cycle after the update is applied.
- Latency from applied update to first tick at the new rate: D_new cycles.

## Test plan
- Reset, then en[0]=1 with DIV_RESET=2: tick[0] pulses every 2 cycles, sq[0] alternates 1,0; other channels stay 0.
- Load ch1 D=5 continuous while IDLE, then en[1]=1: tick every 5 cycles; sq high 3 cycles, low 2; ready[ch1] low for exactly one cycle after the transfer.
- Ch0 running at D=8, load D=3 mid-period at count 4: the current period completes with 8 cycles between ticks, then ticks every 3 cycles. A second load while pending sees ready=0 and is not accepted.
- Load issued exactly on the terminal-count cycle: old period repeats once more before the new D is applied.
- One-shot D=4 on ch2: single tick 4 cycles after enable; done=1 held; no further ticks until en dropped and re-raised.
- Assert rst asynchronously mid-period with D=0 loaded earlier: all outputs drop immediately; after release, each channel runs at DIV_RESET. A separate check confirms D=0 behaves as D=1 (tick every cycle).
